// File: rtl/arima_residual_feeder_if.sv
// arima_residual_feeder_if: observation/prediction input, MA-stage data/control output and status.
interface arima_residual_feeder_if #(parameter int N = 32);
  logic         x_valid;
  logic [N-1:0] x_data;
  logic [N-1:0] pred_data;
  logic         x_ready;
  logic         flush;
  logic [N-1:0] q_order_in;
  logic [N-1:0] ma_data;
  logic [1:0]   ma_control;
  logic         res_valid;
  logic         warm;
  logic         sat;
  modport master (
    output x_valid, x_data, pred_data, flush, q_order_in,
    input  x_ready, ma_data, ma_control, res_valid, warm, sat
  );
  modport slave (
    input  x_valid, x_data, pred_data, flush, q_order_in,
    output x_ready, ma_data, ma_control, res_valid, warm, sat
  );
endinterface

// File: rtl/arima_residual_feeder.sv
// arima_residual_feeder: saturated innovation x - x_hat feeding the MA stage, with clear/stall/shift sequencing.
module arima_residual_feeder #(
  parameter int N     = 32,
  parameter int Q     = 15,
  parameter int q_max = 10
) (
  input logic clk,
  input logic rst_n,
  arima_residual_feeder_if.slave bus
);
  localparam int CW = $clog2(q_max + 1);
  if (Q < 0 || Q >= N) begin : g_bad_q
    $error("Q must lie in [0, N)");
  end
  typedef enum logic [1:0] {CLR, WAIT, SHIFT} state_t;
  state_t       state;
  logic [1:0]   ma_control;
  logic [N-1:0] ma_data;
  logic [CW-1:0] fill_cnt;
  logic         sat;
  logic [N:0]   diff;
  logic         ovf;
  logic [N-1:0] residual;
  logic [CW-1:0] q_eff;
  logic         accept;
  // N+1-bit difference: the top two bits disagree exactly when the result leaves N-bit range
  assign diff     = {bus.x_data[N-1], bus.x_data} - {bus.pred_data[N-1], bus.pred_data};
  assign ovf      = diff[N] ^ diff[N-1];
  assign residual = ovf ? {diff[N], {(N-1){~diff[N]}}} : diff[N-1:0];
  assign q_eff    = (bus.q_order_in > N'(q_max)) ? CW'(q_max) : bus.q_order_in[CW-1:0];
  assign accept   = bus.x_ready & bus.x_valid;
  assign bus.x_ready    = (state == WAIT) & ~bus.flush;
  assign bus.ma_data    = ma_data;
  assign bus.ma_control = ma_control;
  assign bus.res_valid  = ma_control == 2'b00;
  assign bus.warm       = fill_cnt >= q_eff;
  assign bus.sat        = sat;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLR;
      ma_control <= 2'b11;
      ma_data    <= '0;
      fill_cnt   <= '0;
      sat        <= 1'b0;
    end else if (bus.flush) begin
      state      <= CLR;
      ma_control <= 2'b11;
      ma_data    <= '0;
      fill_cnt   <= '0;
      sat        <= 1'b0;
    end else begin
      case (state)
        CLR: begin
          state      <= WAIT;
          ma_control <= 2'b01;
        end
        WAIT: if (accept) begin
          state      <= SHIFT;
          ma_control <= 2'b00;
          ma_data    <= residual;
          sat        <= sat | ovf;
        end
        SHIFT: begin
          state      <= WAIT;
          ma_control <= 2'b01;
          fill_cnt   <= (fill_cnt == CW'(q_max)) ? fill_cnt : fill_cnt + 1'b1;
        end
        default: begin
          state      <= CLR;
          ma_control <= 2'b11;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_arima_residual_feeder.sv
// tb_arima_residual_feeder: directed sequence with a residual scoreboard popped on every MA shift.
module tb_arima_residual_feeder;
  typedef struct {logic [31:0] d; logic s;} exp_t;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  arima_residual_feeder_if #(.N(32)) bus ();
  arima_residual_feeder #(.N(32), .Q(15), .q_max(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_cmp = 0;
  int n_err = 0;
  int n_shift = 0;
  int fill = 0;
  bit m_wait;
  logic exp_sat = 1'b0;
  exp_t sb[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] x, input logic [31:0] p);
    longint d;
    logic [31:0] r;
    d = longint'($signed(x)) - longint'($signed(p));
    if (d > 64'sd2147483647) begin
      r = 32'h7FFF_FFFF;
      exp_sat = 1'b1;
    end else if (d < -64'sd2147483648) begin
      r = 32'h8000_0000;
      exp_sat = 1'b1;
    end else r = d[31:0];
    sb.push_back('{r, exp_sat});
  endtask
  task automatic send(input logic [31:0] x, input logic [31:0] p);
    chk("x_ready_before_send", 32'(bus.x_ready), 32'd1);
    bus.x_valid = 1'b1;
    bus.x_data = x;
    bus.pred_data = p;
    push(x, p);
    step();
    chk("ctrl_shift", 32'(bus.ma_control), 32'd0);
    chk("res_valid_shift", 32'(bus.res_valid), 32'd1);
    chk("x_ready_in_shift", 32'(bus.x_ready), 32'd0);
    bus.x_valid = 1'b0;
    step();
    chk("ctrl_after_shift", 32'(bus.ma_control), 32'd1);
    fill = (fill < 10) ? fill + 1 : 10;
  endtask
  task automatic do_flush(input int k);
    int s;
    bus.flush = 1'b1;
    #1;
    chk("x_ready_flush", 32'(bus.x_ready), 32'd0);
    s = n_shift;
    repeat (k) begin
      step();
      chk("ctrl_clear", 32'(bus.ma_control), 32'd3);
    end
    bus.flush = 1'b0;
    chk("ma_data_clear", bus.ma_data, 32'd0);
    chk("sat_clear", 32'(bus.sat), 32'd0);
    step();
    chk("ctrl_wait_after_flush", 32'(bus.ma_control), 32'd1);
    chk("no_shift_during_flush", 32'(n_shift), 32'(s));
    fill = 0;
    exp_sat = 1'b0;
    m_wait = 1'b1;
  endtask
  task automatic stream(input int cycles, input int qv);
    bit acc;
    int qe;
    qe = (qv > 10) ? 10 : qv;
    bus.q_order_in = 32'(qv);
    for (int i = 0; i < cycles; i++) begin
      acc = m_wait;
      bus.x_valid = 1'b1;
      bus.x_data = $urandom;
      bus.pred_data = $urandom;
      if (acc) push(bus.x_data, bus.pred_data);
      step();
      if (!m_wait) fill = (fill < 10) ? fill + 1 : 10;
      m_wait = !acc;
      chk("stream_x_ready", 32'(bus.x_ready), 32'(m_wait));
      chk("stream_warm", 32'(bus.warm), 32'(fill >= qe));
    end
    bus.x_valid = 1'b0;
    if (!m_wait) begin
      step();
      fill = (fill < 10) ? fill + 1 : 10;
      m_wait = 1'b1;
    end
  endtask
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.res_valid === 1'b1) begin
      n_shift++;
      if (sb.size() == 0) chk("scoreboard_empty", 32'(sb.size()), 32'd1);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("residual", bus.ma_data, e.d);
        chk("sat_at_shift", 32'(bus.sat), 32'(e.s));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int s;
    rst_n = 1'b0;
    bus.x_valid = 1'b0;
    bus.x_data = '0;
    bus.pred_data = '0;
    bus.flush = 1'b0;
    bus.q_order_in = 32'd3;
    step();
    step();
    chk("rst_ctrl", 32'(bus.ma_control), 32'd3);
    chk("rst_ma_data", bus.ma_data, 32'd0);
    chk("rst_x_ready", 32'(bus.x_ready), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_sat", 32'(bus.sat), 32'd0);
    chk("rst_warm_q3", 32'(bus.warm), 32'd0);
    bus.q_order_in = 32'd0;
    #1;
    chk("rst_warm_q0", 32'(bus.warm), 32'd1);
    bus.q_order_in = 32'd3;
    rst_n = 1'b1;
    #1;
    chk("ctrl_before_first_edge", 32'(bus.ma_control), 32'd3);
    step();
    chk("ctrl_first_edge", 32'(bus.ma_control), 32'd1);
    chk("x_ready_wait", 32'(bus.x_ready), 32'd1);
    chk("warm_empty", 32'(bus.warm), 32'd0);
    m_wait = 1'b1;
    send(32'h0001_0000, 32'h0000_8000);
    chk("ma_data_hold", bus.ma_data, 32'h0000_8000);
    chk("sat_after_plain", 32'(bus.sat), 32'd0);
    bus.q_order_in = 32'd1;
    #1;
    chk("warm_fill1_q1", 32'(bus.warm), 32'd1);
    bus.q_order_in = 32'd2;
    #1;
    chk("warm_fill1_q2", 32'(bus.warm), 32'd0);
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF);
    chk("sat_pos", 32'(bus.sat), 32'd1);
    send(32'h8000_0000, 32'h0000_0001);
    chk("sat_sticky", 32'(bus.sat), 32'd1);
    for (int i = 0; i < 6; i++) send($urandom, $urandom);
    bus.x_valid = 1'b1;
    bus.x_data = 32'h1234_5678;
    bus.pred_data = 32'h0;
    do_flush(1);
    bus.x_valid = 1'b0;
    stream(10, 3);
    do_flush(3);
    stream(24, 20);
    do_flush(1);
    bus.q_order_in = 32'd1;
    push(32'h0000_0100, 32'h0000_0001);
    bus.x_valid = 1'b1;
    bus.x_data = 32'h0000_0100;
    bus.pred_data = 32'h0000_0001;
    step();
    bus.x_valid = 1'b0;
    chk("ctrl_shift_pre_abort", 32'(bus.ma_control), 32'd0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    s = n_shift;
    chk("abort_ctrl", 32'(bus.ma_control), 32'd3);
    chk("abort_ma_data", bus.ma_data, 32'd0);
    chk("abort_warm", 32'(bus.warm), 32'd0);
    step();
    chk("abort_wait", 32'(bus.ma_control), 32'd1);
    chk("abort_no_shift", 32'(n_shift), 32'(s));
    fill = 0;
    exp_sat = 1'b0;
    push(32'h0000_0005, 32'h0000_0003);
    bus.x_valid = 1'b1;
    bus.x_data = 32'h0000_0005;
    bus.pred_data = 32'h0000_0003;
    step();
    bus.x_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midshift_rst_ctrl", 32'(bus.ma_control), 32'd3);
    chk("midshift_rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("midshift_rst_ma_data", bus.ma_data, 32'd0);
    sb.delete();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_wait", 32'(bus.ma_control), 32'd1);
    chk("post_rst_warm", 32'(bus.warm), 32'd0);
    send(32'hFFFF_FFF0, 32'h0000_0010);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
